block_allocator: RTL and testbench

BLOCK_ALLOCATOR -- requirements
Module: block_allocator

---
 rtl/block_allocator.sv | 195 +++++++++++++++++++
 tb/tb_block_allocator.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_allocator.sv
// block_allocator: next-fit allocator of fixed-size blocks kept in an external
// single-port RAM. Each block's first word carries an allocated flag in its MSB.
// Block 0 is reserved and never handed out.
module block_allocator #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_WORDS = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alloc_req,
  input  logic                  free_req,
  input  logic [ADDR_WIDTH-1:0] free_address,
  output logic                  busy,
  output logic                  done,
  output logic                  addr_found,
  output logic [ADDR_WIDTH-1:0] out_address,
  output logic                  full,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int unsigned NUM_BLOCKS = (2 ** ADDR_WIDTH) / BLOCK_WORDS;
  // Scan counter only has to reach NUM_BLOCKS-2 (index of the last usable header)
  localparam int unsigned CNT_W      = (NUM_BLOCKS > 2) ? $clog2(NUM_BLOCKS - 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(BLOCK_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_BASE  = ADDR_WIDTH'((NUM_BLOCKS - 1) * BLOCK_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(NUM_BLOCKS - 2);
  localparam logic [DATA_WIDTH-1:0] CLAIM_WORD = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_CLAIM,
    S_FREE_WR,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  addr_found_q, addr_found_d;
  logic [ADDR_WIDTH-1:0] out_address_q, out_address_d;
  logic                  full_q, full_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  ram_wren_q, ram_wren_d;

  logic                  free_bad_c;
  logic [ADDR_WIDTH-1:0] ptr_next_c;

  // Successor block base, wrapping from the last block back to block 1
  always_comb begin
    ptr_next_c = (ptr_q == LAST_BASE) ? STRIDE : ptr_q + STRIDE;
  end

  // A release address is rejected if it is block 0, misaligned or past the last block
  always_comb begin
    free_bad_c = (free_address == '0) ||
                 ((free_address & ALIGN_MASK) != '0) ||
                 (free_address > LAST_BASE);
  end

  // Next-state and next-output logic; outputs are computed for the state being entered
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    addr_found_d  = addr_found_q;
    out_address_d = out_address_q;
    full_d        = full_q;
    error_d       = error_q;
    ram_address_d = ram_address_q;

    unique case (state_q)
      S_IDLE: begin
        if (free_req) begin
          addr_found_d = 1'b0;
          full_d       = 1'b0;
          if (free_bad_c) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            error_d       = 1'b0;
            ram_address_d = free_address;
            state_d       = S_FREE_WR;
          end
        end else if (alloc_req) begin
          addr_found_d  = 1'b0;
          full_d        = 1'b0;
          error_d       = 1'b0;
          ram_address_d = ptr_q;
          cnt_d         = '0;
          state_d       = S_READ;
        end
      end

      S_READ: begin
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if (!ram_q[DATA_WIDTH-1]) begin
          state_d = S_CLAIM;
        end else begin
          // Advancing on every rejection returns ptr to its start after a full lap
          ptr_d = ptr_next_c;
          if (cnt_q == LAST_CNT) begin
            full_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d         = cnt_q + CNT_W'(1);
            ram_address_d = ptr_next_c;
            state_d       = S_READ;
          end
        end
      end

      S_CLAIM: begin
        addr_found_d  = 1'b1;
        out_address_d = ptr_q;
        ptr_d         = ptr_next_c;
        state_d       = S_DONE;
      end

      S_FREE_WR: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    ram_wren_d = (state_d == S_CLAIM) || (state_d == S_FREE_WR);
    ram_data_d = (state_d == S_CLAIM) ? CLAIM_WORD : '0;
  end

  // State, scan pointer and registered outputs; reset aborts any in-flight request
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= STRIDE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      addr_found_q  <= 1'b0;
      out_address_q <= '0;
      full_q        <= 1'b0;
      error_q       <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      addr_found_q  <= addr_found_d;
      out_address_q <= out_address_d;
      full_q        <= full_d;
      error_q       <= error_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign addr_found  = addr_found_q;
  assign out_address = out_address_q;
  assign full        = full_q;
  assign error       = error_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;

endmodule

// File: tb/tb_block_allocator.sv
// Randomized scoreboard bench for block_allocator with a behavioural RAM and
// a block-level reference model of the next-fit allocation rules.
module tb_block_allocator;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 32;
  localparam int NB = (2 ** AW) / BW;

  logic          clock;
  logic          reset;
  logic          alloc_req;
  logic          free_req;
  logic [AW-1:0] free_address;
  logic          busy;
  logic          done;
  logic          addr_found;
  logic [AW-1:0] out_address;
  logic          full;
  logic          error;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  block_allocator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) dut (
    .clock       (clock),
    .reset       (reset),
    .alloc_req   (alloc_req),
    .free_req    (free_req),
    .free_address(free_address),
    .busy        (busy),
    .done        (done),
    .addr_found  (addr_found),
    .out_address (out_address),
    .full        (full),
    .error       (error),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM with a bench-side write port used only while the DUT is idle
  logic [DW-1:0] mem [0:(2**AW)-1];
  logic          poke_en;
  logic [AW-1:0] poke_addr;
  logic [DW-1:0] poke_data;

  always @(posedge clock) begin
    ram_q <= mem[ram_address];
    if (ram_wren) mem[ram_address] <= ram_data;
    else if (poke_en) mem[poke_addr] <= poke_data;
  end

  typedef struct {
    bit            is_alloc;
    bit            found;
    bit            full;
    bit            err;
    logic [AW-1:0] out_addr;
    int            lat;
    int            nwr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: allocated flag per block, scan pointer, last result
  bit            flags [NB];
  int            mptr;
  logic [AW-1:0] last_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model_alloc();
    exp_t e;
    int   bi;
    int   idx;
    e = '{is_alloc: 1'b1, found: 1'b0, full: 1'b1, err: 1'b0, out_addr: last_out,
          lat: 2 * (NB - 1) + 1, nwr: 0, wr_addr: '0, wr_data: '0};
    bi = mptr / BW;
    for (int i = 0; i < NB - 1; i++) begin
      idx = ((bi - 1 + i) % (NB - 1)) + 1;
      if (!flags[idx]) begin
        flags[idx] = 1'b1;
        e.found    = 1'b1;
        e.full     = 1'b0;
        e.out_addr = AW'(idx * BW);
        e.lat      = 4 + 2 * i;
        e.nwr      = 1;
        e.wr_addr  = AW'(idx * BW);
        e.wr_data  = 32'h8000_0000;
        last_out   = AW'(idx * BW);
        mptr       = ((idx % (NB - 1)) + 1) * BW;
        break;
      end
    end
    return e;
  endfunction

  function automatic exp_t model_free(input int addr);
    exp_t e;
    e = '{is_alloc: 1'b0, found: 1'b0, full: 1'b0, err: 1'b1, out_addr: last_out,
          lat: 1, nwr: 0, wr_addr: '0, wr_data: '0};
    if (addr != 0 && (addr % BW) == 0 && addr <= (NB - 1) * BW) begin
      flags[addr / BW] = 1'b0;
      e.err     = 1'b0;
      e.lat     = 2;
      e.nwr     = 1;
      e.wr_addr = AW'(addr);
    end
    return e;
  endfunction

  // Monitor: measures each response and checks it against the oldest expectation
  int            busy_cnt = 0;
  int            wr_cnt   = 0;
  bit            saw_zero = 1'b0;
  logic [AW-1:0] wr_a;
  logic [DW-1:0] wr_d;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
      wr_cnt   = 0;
      saw_zero = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (busy && ram_address == '0) saw_zero = 1'b1;
      if (ram_wren) begin
        wr_cnt++;
        wr_a = ram_address;
        wr_d = ram_data;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no response at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("done_found", 64'(addr_found), 64'(e.found));
          chk("done_full", 64'(full), 64'(e.full));
          chk("done_error", 64'(error), 64'(e.err));
          chk("done_out_address", 64'(out_address), 64'(e.out_addr));
          chk("done_latency", 64'(busy_cnt), 64'(e.lat));
          chk("write_count", 64'(wr_cnt), 64'(e.nwr));
          if (e.nwr > 0) begin
            chk("write_addr", 64'(wr_a), 64'(e.wr_addr));
            chk("write_data", 64'(wr_d), 64'(e.wr_data));
          end
          if (e.is_alloc) chk("scan_skips_block0", 64'(saw_zero), 64'(0));
        end
        busy_cnt = 0;
        wr_cnt   = 0;
        saw_zero = 1'b0;
      end else if (!busy) begin
        busy_cnt = 0;
        wr_cnt   = 0;
        saw_zero = 1'b0;
      end
    end
  end

  task automatic poke(input int addr, input logic [DW-1:0] data);
    @(negedge clock);
    poke_en   = 1'b1;
    poke_addr = AW'(addr);
    poke_data = data;
    @(posedge clock);
    #1 poke_en = 1'b0;
    if ((addr % BW) == 0) flags[addr / BW] = data[DW-1];
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset    = 1'b0;
    mptr     = BW;
    last_out = '0;
  endtask

  // Issue one request, optionally firing stray requests while busy, then wait for IDLE
  task automatic do_req(input bit a, input bit f, input int fa, input bit pulse);
    int n;
    bit stray;
    if (f) exp_q.push_back(model_free(fa));
    else   exp_q.push_back(model_alloc());
    @(negedge clock);
    alloc_req    = a;
    free_req     = f;
    free_address = AW'(fa);
    @(posedge clock);
    #1;
    alloc_req = 1'b0;
    free_req  = 1'b0;
    n     = 0;
    stray = 1'b0;
    while (n < 200) begin
      @(negedge clock);
      n++;
      if (stray) begin
        alloc_req = 1'b0;
        free_req  = 1'b0;
        stray     = 1'b0;
      end
      if (!busy) break;
      if (pulse && n == 2) begin
        alloc_req    = 1'($urandom_range(0, 1));
        free_req     = 1'b1;
        free_address = AW'($urandom_range(1, NB - 1) * BW);
        stray        = 1'b1;
      end
    end
    chk("idle_timeout", 64'(n >= 200), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    int blk;
    reset        = 1'b1;
    alloc_req    = 1'b0;
    free_req     = 1'b0;
    free_address = '0;
    poke_en      = 1'b0;
    poke_addr    = '0;
    poke_data    = '0;
    mptr         = BW;
    last_out     = '0;
    foreach (flags[i]) flags[i] = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_addr_found", 64'(addr_found), 64'(0));
    chk("reset_out_address", 64'(out_address), 64'(0));
    chk("reset_full", 64'(full), 64'(0));
    chk("reset_error", 64'(error), 64'(0));
    chk("reset_ram_address", 64'(ram_address), 64'(0));
    chk("reset_ram_data", 64'(ram_data), 64'(0));
    chk("reset_ram_wren", 64'(ram_wren), 64'(0));
    reset = 1'b0;

    // Zeroed headers: two allocations land at 32 then 64
    for (int b = 0; b < NB; b++) poke(b * BW, '0);
    do_req(1'b1, 1'b0, 0, 1'b0);
    do_req(1'b1, 1'b0, 0, 1'b0);

    // Every header allocated: full after a whole lap
    for (int b = 1; b < NB; b++) poke(b * BW, 32'h8000_0000);
    do_req(1'b1, 1'b0, 0, 1'b0);

    // Valid free, misaligned free, free of block 0
    do_req(1'b0, 1'b1, 64, 1'b0);
    do_req(1'b0, 1'b1, 70, 1'b0);
    do_req(1'b0, 1'b1, 0, 1'b0);

    // Simultaneous alloc and free: free wins, then alloc picks the freed block
    do_req(1'b1, 1'b1, 96, 1'b0);
    do_req(1'b1, 1'b0, 0, 1'b0);

    // Wrap from the last block past block 0 to reach the only free block
    for (int b = 0; b < NB; b++) poke(b * BW, '0);
    do_reset();
    for (int k = 0; k < NB - 2; k++) do_req(1'b1, 1'b0, 0, 1'b0);
    for (int b = 1; b < NB; b++) poke(b * BW, (b == 2) ? 32'h0 : 32'h8000_0000);
    do_req(1'b1, 1'b0, 0, 1'b0);

    // Reset in the middle of a scan: outputs drop at once, no response follows
    for (int b = 1; b < NB; b++) poke(b * BW, 32'h8000_0000);
    @(negedge clock);
    alloc_req = 1'b1;
    @(posedge clock);
    #1 alloc_req = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_ram_wren", 64'(ram_wren), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset    = 1'b0;
    mptr     = BW;
    last_out = '0;
    repeat (3) @(negedge clock);

    // Random headers (noise in low bits) and a random mix of requests
    for (int b = 0; b < NB; b++)
      poke(b * BW, {1'($urandom_range(0, 1)), 31'($urandom)});
    for (int k = 0; k < 150; k++) begin
      r   = $urandom_range(0, 99);
      blk = $urandom_range(1, NB - 1);
      if (r < 55)
        do_req(1'b1, 1'b0, 0, ($urandom_range(0, 3) == 0));
      else if (r < 80)
        do_req(1'b0, 1'b1, blk * BW, ($urandom_range(0, 3) == 0));
      else if (r < 90)
        do_req(1'b0, 1'b1, ($urandom_range(0, 1) == 0) ? 0 : blk * BW + $urandom_range(1, BW - 1), 1'b0);
      else
        do_req(1'b1, 1'b1, blk * BW, 1'b0);
    end

    repeat (4) @(negedge clock);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    for (int b = 1; b < NB; b++) chk("final_header_flag", 64'(mem[b * BW][DW-1]), 64'(flags[b]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
